// File: rtl/adc_pkg.sv
// adc_pkg: shared constants, scan states and lowest-set-bit helper for the ADC scan block
package adc_pkg;
  localparam int NUM_CH = 8;
  localparam int BITS = 10;
  localparam int TIMEOUT = 64;
  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(BITS);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, SELECT, CONV, SHIFT, DONE} state_t;
  function automatic logic [CW-1:0] lsb_idx(input logic [NUM_CH-1:0] v);
    lsb_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) lsb_idx = CW'(i);
  endfunction
endpackage

// File: rtl/adc_prio_enc.sv
// adc_prio_enc: index of the lowest set bit of a channel vector plus a non-empty flag
module adc_prio_enc
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] vec,
  output logic [CW-1:0]     idx,
  output logic              valid
);
  assign idx = lsb_idx(vec);
  assign valid = |vec;
endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sequences conversion and serial capture across the enabled ADC channels
module adc_scan_ctrl
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              bit_valid,
  output logic              conv_start,
  output logic [NUM_CH-1:0] adc_sel,
  output logic [CW-1:0]     ch_idx,
  output logic              chan_done,
  output logic              timeout_err,
  output logic              frame_done,
  output logic              busy
);
  state_t state, state_n;
  logic [NUM_CH-1:0] pending, pending_n, oh, rem, enc_in;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic [CW-1:0] ch_idx_n, enc_idx;
  logic aborted, aborted_n, enc_vld, last_bit, expire;
  assign oh = NUM_CH'(1) << ch_idx;
  assign rem = pending & ~oh;
  assign enc_in = (state == SELECT) ? pending : rem;
  adc_prio_enc u_enc (.vec(enc_in), .idx(enc_idx), .valid(enc_vld));
  assign last_bit = bit_valid && bit_cnt == BW'(BITS - 1);
  // a bit arriving on the threshold cycle wins over the timeout
  assign expire = state == SHIFT && !bit_valid && wait_cnt == WW'(TIMEOUT - 1);
  assign conv_start = state == CONV;
  assign adc_sel = (state == SHIFT && bit_valid) ? oh : '0;
  assign chan_done = state == DONE && !aborted;
  assign frame_done = state == DONE && !enc_vld;
  assign timeout_err = expire;
  assign busy = state != IDLE;
  // state and scan bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      bit_cnt <= '0;
      wait_cnt <= '0;
      ch_idx <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      bit_cnt <= bit_cnt_n;
      wait_cnt <= wait_cnt_n;
      ch_idx <= ch_idx_n;
      aborted <= aborted_n;
    end
  end
  // next-state: pick channel, trigger, count bits or give up, then advance the frame
  always_comb begin
    state_n = state;
    pending_n = pending;
    bit_cnt_n = bit_cnt;
    wait_cnt_n = wait_cnt;
    ch_idx_n = ch_idx;
    aborted_n = aborted;
    case (state)
      IDLE: if (start && |chan_mask) begin
        pending_n = chan_mask;
        state_n = SELECT;
      end
      SELECT: begin
        ch_idx_n = enc_idx;
        bit_cnt_n = '0;
        wait_cnt_n = '0;
        aborted_n = 1'b0;
        state_n = CONV;
      end
      CONV: state_n = SHIFT;
      SHIFT: if (bit_valid) begin
        bit_cnt_n = bit_cnt + 1'b1;
        wait_cnt_n = '0;
        state_n = last_bit ? DONE : SHIFT;
      end else if (expire) begin
        pending_n = rem;
        aborted_n = 1'b1;
        state_n = enc_vld ? SELECT : DONE;
      end else begin
        wait_cnt_n = wait_cnt + 1'b1;
      end
      DONE: begin
        pending_n = (!enc_vld && cont) ? chan_mask : rem;
        state_n = (enc_vld || (cont && |chan_mask)) ? SELECT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed and randomized checks of adc_scan_ctrl against a timeline model
module tb_adc_scan_ctrl;
  import adc_pkg::*;
  logic clk = 1'b0;
  logic rst, start, cont, bit_valid;
  logic [7:0] chan_mask;
  logic conv_start, chan_done, timeout_err, frame_done, busy;
  logic [7:0] adc_sel;
  logic [2:0] ch_idx;
  always #5 clk = ~clk;
  adc_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .chan_mask(chan_mask),
    .bit_valid(bit_valid), .conv_start(conv_start), .adc_sel(adc_sel),
    .ch_idx(ch_idx), .chan_done(chan_done), .timeout_err(timeout_err),
    .frame_done(frame_done), .busy(busy)
  );
  int checks = 0, errors = 0;
  bit mb, ending, abort;
  logic [7:0] pend;
  int ch, t, bits, idle;
  int cyc, sel_cnt, conv_cnt, done_cnt, to_cnt, frame_cnt;
  int last_sel, last_conv, last_done, last_done_ch, last_to, last_to_ch, last_frame, last_frame_ch;
  bit frame_with_done;
  int bv_mode, ph, gap;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction
  task automatic step();
    logic [15:0] exp, act;
    logic [7:0] oh, rem;
    @(negedge clk);
    cyc++;
    oh = 8'(1) << ch;
    exp = '0;
    if (mb) begin
      exp[15] = 1'b1;
      if (ending) begin
        exp[12] = !abort;
        exp[14] = (pend & ~oh) == 0;
      end else if (t == 1) exp[11] = 1'b1;
      else if (t >= 2) begin
        exp[7:0] = bit_valid ? oh : 8'h00;
        exp[13] = !bit_valid && idle == TIMEOUT - 1;
      end
    end
    exp[10:8] = 3'(ch);
    act = {busy, frame_done, timeout_err, chan_done, conv_start, ch_idx, adc_sel};
    chk("outputs", 32'(act), 32'(exp));
    if (adc_sel != 0) begin sel_cnt++; last_sel = cyc; end
    if (conv_start) begin conv_cnt++; last_conv = cyc; end
    if (chan_done) begin done_cnt++; last_done = cyc; last_done_ch = int'(ch_idx); end
    if (timeout_err) begin to_cnt++; last_to = cyc; last_to_ch = int'(ch_idx); end
    if (frame_done) begin frame_cnt++; last_frame = cyc; last_frame_ch = int'(ch_idx); frame_with_done = chan_done; end
    if (rst) begin
      mb = 0; pend = 0; ch = 0; t = 0; bits = 0; idle = 0; ending = 0; abort = 0;
    end else if (!mb) begin
      if (start && chan_mask != 0) begin mb = 1; pend = chan_mask; t = 0; ending = 0; end
    end else if (ending) begin
      rem = pend & ~oh;
      ending = 0;
      t = 0;
      if (rem != 0) pend = rem;
      else if (cont && chan_mask != 0) pend = chan_mask;
      else begin pend = 0; mb = 0; end
    end else if (t == 0) begin
      ch = lowest(pend); bits = 0; idle = 0; abort = 0; t = 1;
    end else if (t == 1) t = 2;
    else if (bit_valid) begin
      bits++; idle = 0;
      if (bits == BITS) ending = 1;
    end else if (idle == TIMEOUT - 1) begin
      pend &= ~oh; abort = 1;
      if (pend != 0) t = 0; else ending = 1;
    end else idle++;
    @(posedge clk);
    #1;
    case (bv_mode)
      0: bit_valid = 1'b0;
      1: bit_valid = 1'b1;
      2: begin ph = (ph + 1) % 3; bit_valid = ph == 0; end
      3: if (gap > 0) begin gap--; bit_valid = 1'b0; end
         else begin
           bit_valid = $urandom_range(0, 5) != 0;
           if ($urandom_range(0, 60) == 0) gap = $urandom_range(55, 70);
         end
      default: ;
    endcase
  endtask
  int c0, b_sel, b_conv, b_done, b_to, b_frame, bit4, f1;
  task automatic snap();
    c0 = cyc; b_sel = sel_cnt; b_conv = conv_cnt; b_done = done_cnt; b_to = to_cnt; b_frame = frame_cnt;
  endtask
  task automatic kick(input logic [7:0] m);
    chan_mask = m; start = 1'b1;
    step();
    snap();
    start = 1'b0;
  endtask
  initial begin
    rst = 1; start = 0; cont = 0; chan_mask = 0; bit_valid = 0; bv_mode = 0; ph = 0; gap = 0;
    mb = 0; pend = 0; ch = 0; t = 0; bits = 0; idle = 0; ending = 0; abort = 0;
    cyc = 0; sel_cnt = 0; conv_cnt = 0; done_cnt = 0; to_cnt = 0; frame_cnt = 0; frame_with_done = 0;
    #1;
    repeat (3) step();
    rst = 0;
    step();
    chk("reset_outs", 32'({busy, frame_done, timeout_err, chan_done, conv_start, ch_idx, adc_sel}), 32'h0);
    bv_mode = 1;
    kick(8'b0000_0101);
    repeat (30) step();
    chk("t1_enables", sel_cnt - b_sel, 20);
    chk("t1_convs", conv_cnt - b_conv, 2);
    chk("t1_frame_latency", last_frame - c0, 26);
    chk("t1_frame_ch", last_frame_ch, 2);
    chk("t1_frame_with_done", 32'(frame_with_done), 1);
    chk("t1_idle", 32'(busy), 0);
    bv_mode = 2;
    kick(8'h80);
    repeat (45) step();
    chk("t2_enables", sel_cnt - b_sel, 10);
    chk("t2_timeouts", to_cnt - b_to, 0);
    chk("t2_done_ch", last_done_ch, 7);
    chk("t2_dones", done_cnt - b_done, 1);
    bv_mode = 4;
    bit_valid = 1;
    kick(8'h03);
    repeat (6) step();
    bit4 = last_sel;
    bit_valid = 0;
    repeat (70) step();
    bit_valid = 1;
    repeat (25) step();
    chk("t3_bits_before_to", sel_cnt - b_sel, 14);
    chk("t3_to_delay", last_to - bit4, 64);
    chk("t3_to_ch", last_to_ch, 0);
    chk("t3_timeouts", to_cnt - b_to, 1);
    chk("t3_dones", done_cnt - b_done, 1);
    chk("t3_frame_ch", last_frame_ch, 1);
    chk("t3_frame_with_done", 32'(frame_with_done), 1);
    bv_mode = 1;
    kick(8'h00);
    repeat (3) step();
    chk("t4_zero_busy", 32'(busy), 0);
    chk("t4_zero_conv", conv_cnt - b_conv, 0);
    kick(8'h02);
    repeat (5) step();
    chan_mask = 8'hFF; start = 1;
    step();
    start = 0;
    repeat (15) step();
    chk("t4_busy_convs", conv_cnt - b_conv, 1);
    chk("t4_busy_dones", done_cnt - b_done, 1);
    chk("t4_busy_done_ch", last_done_ch, 1);
    chk("t4_busy_frames", frame_cnt - b_frame, 1);
    cont = 1;
    kick(8'h10);
    repeat (14) step();
    f1 = last_frame;
    cont = 0;
    repeat (20) step();
    chk("t5_reconv_gap", last_conv - f1, 2);
    chk("t5_frames", frame_cnt - b_frame, 2);
    chk("t5_convs", conv_cnt - b_conv, 2);
    kick(8'h08);
    repeat (7) step();
    chk("t6_bits_before_rst", sel_cnt - b_sel, 5);
    rst = 1;
    step();
    rst = 0;
    chk("t6_reset_outs", 32'({busy, frame_done, timeout_err, chan_done, conv_start, ch_idx, adc_sel}), 32'h0);
    kick(8'h08);
    repeat (14) step();
    chk("t6_enables", sel_cnt - b_sel, 10);
    chk("t6_done_ch", last_done_ch, 3);
    chk("t6_frames", frame_cnt - b_frame, 1);
    bv_mode = 3;
    repeat (5000) begin
      start = $urandom_range(0, 19) == 0;
      chan_mask = 8'($urandom);
      if ($urandom_range(0, 7) == 0) chan_mask = 8'h00;
      if ($urandom_range(0, 40) == 0) cont = ~cont;
      rst = $urandom_range(0, 700) == 0;
      step();
    end
    rst = 0; start = 0; cont = 0;
    repeat (20) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
